// File: rtl/bus_arbiter_pkg.sv
// Shared types for the two-requester APB bus arbiter.
// Holds the FSM state encoding, the pending-slot record and the grant selector.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        write;
    } slot_t;

    // Returns the winning requester index (0 or 1); only meaningful when a slot is valid.
    function automatic logic pick_req(
        input logic i_v0,
        input logic i_v1,
        input logic i_rr_last,
        input logic i_fixed
    );
        if (i_fixed)
            return !i_v0;
        if (i_v0 && i_v1)
            return !i_rr_last;
        return !i_v0;
    endfunction

endpackage

// File: rtl/bus_arbiter_req_slot.sv
// One pending-request slot with a sticky overrun flag.
// A completion clearing the slot frees it for a pulse in that same cycle.
module req_slot
    import bus_arbiter_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_pulse,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_write,
    input  logic        i_clear,
    output logic        o_valid,
    output logic [31:0] o_addr,
    output logic [31:0] o_wdata,
    output logic        o_write,
    output logic        o_overrun
);

    slot_t r_slot;
    logic  r_overrun;
    logic  w_free;

    assign w_free = !r_slot.valid || i_clear;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_slot    <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (i_pulse && w_free)
                r_slot <= '{valid: 1'b1, addr: i_addr,
                            wdata: i_wdata, write: i_write};
            else if (i_clear)
                r_slot.valid <= 1'b0;
            if (i_pulse && !w_free)
                r_overrun <= 1'b1;
        end
    end

    assign o_valid   = r_slot.valid;
    assign o_addr    = r_slot.addr;
    assign o_wdata   = r_slot.wdata;
    assign o_write   = r_slot.write;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/bus_arbiter.sv
// Two-requester (CPU/DMA) arbiter in front of an APB manager port.
// Round-robin or fixed-priority grant; one transfer in flight at a time.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        m0_transfer,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_write,
    output logic [31:0] m0_rdata,
    output logic        m0_ready,
    input  logic        m1_transfer,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_write,
    output logic [31:0] m1_rdata,
    output logic        m1_ready,
    output logic        transfer,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    output logic        write,
    input  logic [31:0] rdata,
    input  logic        ready,
    output logic [1:0]  overrun
);

    slot_t       w_s0;
    slot_t       w_s1;
    logic        w_busy;
    logic        w_done;
    logic        w_clr0;
    logic        w_clr1;
    logic        w_sel;

    state_t      r_state;
    logic        r_owner;
    logic        r_rr_last;
    logic        r_transfer;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_write;
    logic [31:0] r_rdata0;
    logic [31:0] r_rdata1;

    req_slot u_slot0 (
        .i_clk     (PCLK),
        .i_rst_n   (PRESET),
        .i_pulse   (m0_transfer),
        .i_addr    (m0_addr),
        .i_wdata   (m0_wdata),
        .i_write   (m0_write),
        .i_clear   (w_clr0),
        .o_valid   (w_s0.valid),
        .o_addr    (w_s0.addr),
        .o_wdata   (w_s0.wdata),
        .o_write   (w_s0.write),
        .o_overrun (overrun[0])
    );

    req_slot u_slot1 (
        .i_clk     (PCLK),
        .i_rst_n   (PRESET),
        .i_pulse   (m1_transfer),
        .i_addr    (m1_addr),
        .i_wdata   (m1_wdata),
        .i_write   (m1_write),
        .i_clear   (w_clr1),
        .o_valid   (w_s1.valid),
        .o_addr    (w_s1.addr),
        .o_wdata   (w_s1.wdata),
        .o_write   (w_s1.write),
        .o_overrun (overrun[1])
    );

    assign w_busy = (r_state == ISSUE) || (r_state == WAIT);
    assign w_done = ready && w_busy;
    assign w_clr0 = w_done && !r_owner;
    assign w_clr1 = w_done && r_owner;
    assign w_sel  = pick_req(w_s0.valid, w_s1.valid, r_rr_last, FIXED_PRIO);

    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            r_state    <= IDLE;
            r_owner    <= 1'b0;
            r_rr_last  <= 1'b1;
            r_transfer <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_write    <= 1'b0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
        end else begin
            r_transfer <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_s0.valid || w_s1.valid) begin
                        r_owner    <= w_sel;
                        r_addr     <= w_sel ? w_s1.addr  : w_s0.addr;
                        r_wdata    <= w_sel ? w_s1.wdata : w_s0.wdata;
                        r_write    <= w_sel ? w_s1.write : w_s0.write;
                        r_transfer <= 1'b1;
                        r_state    <= ISSUE;
                    end
                end
                ISSUE:   r_state <= ready ? IDLE : WAIT;
                WAIT:    if (ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
            if (w_done) begin
                r_rr_last <= r_owner;
                if (r_owner)
                    r_rdata1 <= rdata;
                else
                    r_rdata0 <= rdata;
            end
        end
    end

    // Read data is forwarded in the completion cycle, then held per requester.
    assign m0_ready = w_clr0;
    assign m1_ready = w_clr1;
    assign m0_rdata = w_clr0 ? rdata : r_rdata0;
    assign m1_rdata = w_clr1 ? rdata : r_rdata1;
    assign transfer = r_transfer;
    assign addr     = r_addr;
    assign wdata    = r_wdata;
    assign write    = r_write;

endmodule
